// File: rtl/matmul_batch_sequencer_if.sv
// rtl/matmul_batch_sequencer_if.sv - element, coprocessor and result handshake bundle for the batch sequencer
interface matmul_batch_sequencer_if #(
   parameter int DATA_W = 32
);
   logic              in_valid_i;
   logic [DATA_W-1:0] in_a_i;
   logic [DATA_W-1:0] in_b_i;
   logic              in_ready_o;
   logic              flush_i;

   logic              cp_req_o;
   logic [DATA_W-1:0] cp_src0_o;
   logic [DATA_W-1:0] cp_src1_o;
   logic              cp_ack_i;
   logic              cp_resp_req_i;
   logic [DATA_W-1:0] cp_resp_data_i;
   logic              cp_resp_ack_o;

   logic              out_valid_o;
   logic [DATA_W-1:0] out_data_o;
   logic              out_ready_i;

   logic              busy_o;
   logic              batch_done_o;

   modport master (
      input  in_valid_i, in_a_i, in_b_i, flush_i,
      input  cp_ack_i, cp_resp_req_i, cp_resp_data_i,
      input  out_ready_i,
      output in_ready_o,
      output cp_req_o, cp_src0_o, cp_src1_o, cp_resp_ack_o,
      output out_valid_o, out_data_o,
      output busy_o, batch_done_o
   );

   modport slave (
      output in_valid_i, in_a_i, in_b_i, flush_i,
      output cp_ack_i, cp_resp_req_i, cp_resp_data_i,
      output out_ready_i,
      input  in_ready_o,
      input  cp_req_o, cp_src0_o, cp_src1_o, cp_resp_ack_o,
      input  out_valid_o, out_data_o,
      input  busy_o, batch_done_o
   );
endinterface

// File: rtl/matmul_batch_sequencer.sv
// rtl/matmul_batch_sequencer.sv - batches (A,B) pairs into custom0 coprocessor requests and buffers returned results
module matmul_batch_sequencer #(
   parameter int DATA_W         = 32,
   parameter int BATCH          = 64,
   parameter int COMPUTE_CYCLES = 24,
   parameter int RES_DEPTH      = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   matmul_batch_sequencer_if.master bus
);
   localparam int CNT_W = (BATCH > 1) ? $clog2(BATCH) : 1;
   localparam int TMR_W = $clog2(COMPUTE_CYCLES + 1);
   localparam int PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, FLUSH, COMPUTE} state_t;

   state_t            state;
   logic              cp_req_q;
   logic [DATA_W-1:0] src0_q;
   logic [DATA_W-1:0] src1_q;
   logic              outstanding;
   logic              have_prev;
   logic              is_flush;
   logic              batch_done_q;
   logic [CNT_W-1:0]  resp_cnt;
   logic [TMR_W-1:0]  timer;

   logic [DATA_W-1:0] mem [RES_DEPTH];
   logic [PTR_W-1:0]  wptr;
   logic [PTR_W-1:0]  rptr;
   logic [PTR_W:0]    fifo_count;

   logic issue_ok;
   logic in_ready;
   logic in_fire;
   logic ack_fire;
   logic resp_fire;
   logic push;
   logic pop;

   // FIFO space is reserved before issue, so the one outstanding response always fits
   assign issue_ok  = !outstanding && !cp_req_q && (fifo_count < (PTR_W+1)'(RES_DEPTH));
   assign in_ready  = (state == LOAD) && issue_ok;
   assign in_fire   = bus.in_valid_i && in_ready;
   assign ack_fire  = cp_req_q && bus.cp_ack_i;
   assign resp_fire = bus.cp_resp_req_i && ((state == LOAD) || (state == FLUSH));
   assign push      = resp_fire && have_prev;
   assign pop       = (fifo_count != '0) && bus.out_ready_i;

   assign bus.in_ready_o    = in_ready;
   assign bus.cp_req_o      = cp_req_q;
   assign bus.cp_src0_o     = src0_q;
   assign bus.cp_src1_o     = src1_q;
   assign bus.cp_resp_ack_o = bus.cp_resp_req_i;
   assign bus.out_valid_o   = (fifo_count != '0);
   assign bus.out_data_o    = (fifo_count != '0) ? mem[rptr] : '0;
   assign bus.busy_o        = (state != IDLE);
   assign bus.batch_done_o  = batch_done_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state        <= IDLE;
         cp_req_q     <= 1'b0;
         src0_q       <= '0;
         src1_q       <= '0;
         outstanding  <= 1'b0;
         have_prev    <= 1'b0;
         is_flush     <= 1'b0;
         batch_done_q <= 1'b0;
         resp_cnt     <= '0;
         timer        <= '0;
      end else begin
         batch_done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.in_valid_i) begin
                  state    <= LOAD;
                  is_flush <= 1'b0;
               end else if (bus.flush_i && have_prev) begin
                  state    <= FLUSH;
                  is_flush <= 1'b1;
               end
            end
            LOAD: begin
               if (in_fire) begin
                  cp_req_q <= 1'b1;
                  src0_q   <= bus.in_a_i;
                  src1_q   <= bus.in_b_i;
               end
            end
            FLUSH: begin
               if (issue_ok) begin
                  cp_req_q <= 1'b1;
                  src0_q   <= '0;
                  src1_q   <= '0;
               end
            end
            COMPUTE: begin
               if (timer == '0) begin
                  state        <= IDLE;
                  batch_done_q <= 1'b1;
                  have_prev    <= !is_flush;
               end else begin
                  timer <= timer - TMR_W'(1);
               end
            end
            default: state <= IDLE;
         endcase

         if (ack_fire) begin
            cp_req_q    <= 1'b0;
            outstanding <= 1'b1;
         end
         // a response in the same cycle as its ack wins over the ack setting outstanding
         if (bus.cp_resp_req_i) begin
            outstanding <= 1'b0;
         end
         if (resp_fire) begin
            if (resp_cnt == CNT_W'(BATCH - 1)) begin
               resp_cnt <= '0;
               state    <= COMPUTE;
               timer    <= TMR_W'(COMPUTE_CYCLES - 1);
            end else begin
               resp_cnt <= resp_cnt + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wptr       <= '0;
         rptr       <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wptr <= wptr + PTR_W'(1);
         if (pop)  rptr <= rptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + (PTR_W+1)'(1);
            2'b01:   fifo_count <= fifo_count - (PTR_W+1)'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem[wptr] <= bus.cp_resp_data_i;
   end
endmodule

// File: tb/tb_matmul_batch_sequencer.sv
// tb/tb_matmul_batch_sequencer.sv - scoreboard bench for matmul_batch_sequencer with an ideal coprocessor model
module tb_matmul_batch_sequencer;
   localparam int DW    = 32;
   localparam int BATCH = 64;
   localparam int CC    = 24;
   localparam int DEPTH = 8;

   typedef logic [DW-1:0] mat_t [BATCH];

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   always #5 clk_i = ~clk_i;

   matmul_batch_sequencer_if #(.DATA_W(DW)) bus ();

   matmul_batch_sequencer #(
      .DATA_W(DW), .BATCH(BATCH), .COMPUTE_CYCLES(CC), .RES_DEPTH(DEPTH)
   ) dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .bus  (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   logic [DW-1:0] exp_q[$];
   int   cyc = 0;
   int   results = 0;
   int   done_cnt = 0;
   int   done_cyc = 0;
   int   ack_delay = 0;
   int   stray_pend = 0;
   int   m_idx = 0;
   int   last_resp_cyc = 0;
   int   last_nonzero = 0;
   mat_t ma, mb, prev_c;

   function automatic void mul(input mat_t a, input mat_t b, output mat_t c);
      for (int r = 0; r < 8; r++)
         for (int col = 0; col < 8; col++) begin
            logic [DW-1:0] s;
            s = '0;
            for (int k = 0; k < 8; k++) s += a[r*8+k] * b[k*8+col];
            c[r*8+col] = s;
         end
   endfunction

   initial forever begin
      @(posedge clk_i);
      cyc++;
   end

   // coprocessor: acks after ack_delay cycles, responds with C of the previous batch alongside the ack
   initial begin
      logic [DW-1:0] snap0, snap1;
      logic held;
      int   wait_cnt;
      mat_t c;
      held = 1'b0; wait_cnt = 0; snap0 = '0; snap1 = '0;
      for (int i = 0; i < BATCH; i++) prev_c[i] = '0;
      bus.cp_ack_i = 1'b0; bus.cp_resp_req_i = 1'b0; bus.cp_resp_data_i = '0;
      forever begin
         @(posedge clk_i); #1;
         bus.cp_ack_i = 1'b0; bus.cp_resp_req_i = 1'b0; bus.cp_resp_data_i = '0;
         if (rst_i) begin
            m_idx = 0; wait_cnt = 0; held = 1'b0;
         end else if (bus.cp_req_o) begin
            if (held) begin
               check("src0_stable", bus.cp_src0_o, snap0);
               check("src1_stable", bus.cp_src1_o, snap1);
            end
            held = 1'b1; snap0 = bus.cp_src0_o; snap1 = bus.cp_src1_o;
            if (wait_cnt >= ack_delay) begin
               bus.cp_ack_i = 1'b1; bus.cp_resp_req_i = 1'b1;
               bus.cp_resp_data_i = prev_c[m_idx];
               ma[m_idx] = snap0; mb[m_idx] = snap1;
               m_idx++; wait_cnt = 0; held = 1'b0;
               if (m_idx == BATCH) begin
                  mul(ma, mb, c);
                  prev_c = c;
                  last_nonzero = 0;
                  for (int i = 0; i < BATCH; i++) if (ma[i] != 0 || mb[i] != 0) last_nonzero++;
                  m_idx = 0;
                  last_resp_cyc = cyc + 1;
               end
            end else begin
               wait_cnt++;
            end
         end else begin
            held = 1'b0;
            if (stray_pend > 0) begin
               bus.cp_resp_req_i = 1'b1;
               bus.cp_resp_data_i = 32'hBAD0_0000 | stray_pend;
               stray_pend--;
               #1 check("stray_acked", bus.cp_resp_ack_o, 1);
            end
         end
      end
   end

   initial forever begin
      @(negedge clk_i);
      if (!rst_i && bus.out_valid_o && bus.out_ready_i) begin
         check("sb_has_entry", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) check($sformatf("result_%0d", results), bus.out_data_o, exp_q.pop_front());
         results++;
      end
      if (!rst_i && bus.batch_done_o) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   task automatic send_pair(input logic [DW-1:0] a, input logic [DW-1:0] b);
      int t;
      t = 0;
      bus.in_valid_i = 1'b1; bus.in_a_i = a; bus.in_b_i = b;
      @(negedge clk_i);
      while (!bus.in_ready_o && t < 500) begin
         @(negedge clk_i);
         t++;
      end
      if (t >= 500) check("in_accept_timeout", 0, 1);
      @(posedge clk_i); #1;
      bus.in_valid_i = 1'b0;
   endtask

   task automatic pulse_flush();
      bus.flush_i = 1'b1;
      @(posedge clk_i); #1;
      bus.flush_i = 1'b0;
   endtask

   task automatic wait_done(input int d);
      int t;
      t = 0;
      while (done_cnt == d && t < 3000) begin
         @(negedge clk_i);
         t++;
      end
      check("batch_done_seen", done_cnt > d, 1);
   endtask

   task automatic pulse_reset();
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
   endtask

   initial begin
      mat_t a, b, c;
      int   d, lr, t;
      bus.in_valid_i = 1'b0; bus.in_a_i = '0; bus.in_b_i = '0;
      bus.flush_i = 1'b0; bus.out_ready_i = 1'b1;

      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      check("rst_in_ready", bus.in_ready_o, 0);
      check("rst_cp_req", bus.cp_req_o, 0);
      check("rst_src0", bus.cp_src0_o, 0);
      check("rst_src1", bus.cp_src1_o, 0);
      check("rst_out_valid", bus.out_valid_o, 0);
      check("rst_out_data", bus.out_data_o, 0);
      check("rst_busy", bus.busy_o, 0);
      check("rst_batch_done", bus.batch_done_o, 0);
      check("rst_resp_ack", bus.cp_resp_ack_o, 0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;

      pulse_flush();
      repeat (2) @(negedge clk_i);
      check("flush_idle_noprev_busy", bus.busy_o, 0);

      // asynchronous reset in the middle of a LOAD batch
      for (int i = 0; i < 10; i++) send_pair(100 + i, 200 + i);
      @(negedge clk_i);
      check("load_busy", bus.busy_o, 1);
      #2 rst_i = 1'b1;
      #1;
      check("midrst_in_ready", bus.in_ready_o, 0);
      check("midrst_cp_req", bus.cp_req_o, 0);
      check("midrst_src0", bus.cp_src0_o, 0);
      check("midrst_src1", bus.cp_src1_o, 0);
      check("midrst_out_valid", bus.out_valid_o, 0);
      check("midrst_busy", bus.busy_o, 0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;

      d = done_cnt;
      for (int i = 0; i < BATCH; i++) send_pair($urandom, $urandom);
      wait_done(d);
      repeat (5) @(negedge clk_i);
      check("fresh_no_results", results, 0);
      check("fresh_done_once", done_cnt, d + 1);

      pulse_reset();

      // batch 1: identity times ramp, slow acks, flush ignored in LOAD
      ack_delay = 3;
      for (int i = 0; i < BATCH; i++) begin
         a[i] = (i / 8 == i % 8) ? 1 : 0;
         b[i] = i;
      end
      mul(a, b, c);
      for (int i = 0; i < BATCH; i++) exp_q.push_back(c[i]);
      d = done_cnt;
      for (int i = 0; i < BATCH; i++) begin
         send_pair(a[i], b[i]);
         if (i == 5) begin
            pulse_flush();
            @(negedge clk_i);
            check("flush_in_load_busy", bus.busy_o, 1);
         end
      end
      wait_done(d);
      check("b1_done_latency", done_cyc - last_resp_cyc, CC);
      check("b1_no_results", results, 0);

      // batch 2: consumer stalled until the FIFO fills
      ack_delay = 0;
      @(posedge clk_i); #1;
      bus.out_ready_i = 1'b0;
      for (int i = 0; i < BATCH; i++) begin
         a[i] = $urandom_range(0, 1000);
         b[i] = $urandom_range(0, 1000);
      end
      mul(a, b, c);
      for (int i = 0; i < BATCH; i++) exp_q.push_back(c[i]);
      d = done_cnt;
      lr = last_resp_cyc;
      for (int i = 0; i < 8; i++) send_pair(a[i], b[i]);
      repeat (20) @(negedge clk_i);
      check("stall_cp_req", bus.cp_req_o, 0);
      check("stall_in_ready", bus.in_ready_o, 0);
      check("stall_out_valid", bus.out_valid_o, 1);
      check("stall_req_count", m_idx, 8);
      check("stall_no_pops", results, 0);
      @(posedge clk_i); #1;
      bus.out_ready_i = 1'b1;
      for (int i = 8; i < BATCH; i++) send_pair(a[i], b[i]);
      t = 0;
      while (last_resp_cyc == lr && t < 3000) begin
         @(negedge clk_i);
         t++;
      end
      check("b2_last_resp_seen", last_resp_cyc != lr, 1);
      stray_pend = 3;
      wait_done(d);
      check("b2_done_latency", done_cyc - last_resp_cyc, CC);
      repeat (3) @(negedge clk_i);
      check("b2_out_drained", bus.out_valid_o, 0);
      check("b2_result_count", results, 64);

      // flush batch drains batch 2's results with zero operands
      @(posedge clk_i); #1;
      d = done_cnt;
      pulse_flush();
      @(negedge clk_i);
      check("flush_busy", bus.busy_o, 1);
      check("flush_in_ready", bus.in_ready_o, 0);
      wait_done(d);
      repeat (3) @(negedge clk_i);
      check("total_results", results, 128);
      check("sb_empty_end", exp_q.size(), 0);
      check("flush_zero_ops", last_nonzero, 0);

      @(posedge clk_i); #1;
      pulse_flush();
      repeat (2) @(negedge clk_i);
      check("flush_after_flush_busy", bus.busy_o, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
